// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the CPU control sequencers.
//
// Holds the instruction-class encodings and the branch_sequencer state
// encoding. The states are plain localparam constants so older blocks that
// compare raw state codes keep working unchanged.
package cpu_ctrl_pkg;

  // Instruction classes carried on op (low two bits).
  localparam logic [1:0] OP_BR  = 2'b00;  // conditional branch
  localparam logic [1:0] OP_JR  = 2'b01;  // jump register
  localparam logic [1:0] OP_JAL = 2'b10;  // jump and link
  localparam logic [1:0] OP_RSV = 2'b11;  // reserved, flagged as illegal

  // branch_sequencer state encoding.
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_EVAL = 3'd1;
  localparam logic [ST_W-1:0] ST_ADDR = 3'd2;
  localparam logic [ST_W-1:0] ST_SUM  = 3'd3;
  localparam logic [ST_W-1:0] ST_LOAD = 3'd4;
  localparam logic [ST_W-1:0] ST_LINK = 3'd5;
  localparam logic [ST_W-1:0] ST_JUMP = 3'd6;
  localparam logic [ST_W-1:0] ST_FIN  = 3'd7;

endpackage : cpu_ctrl_pkg

// File: rtl/branch_sequencer.sv
// branch_sequencer: control FSM that sequences the datapath strobes for the
// BR, JR and JAL instruction classes.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   start      request to run the instruction on op (sampled only in IDLE)
//   op         instruction class: 00 BR, 01 JR, 10 JAL, 11 reserved
//   con_q      condition flip-flop output, decides whether BR loads the PC
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse (FIN)
//   taken      registered outcome of the most recent BR
//   illegal    one-cycle pulse in FIN when the latched op is reserved
//   Gra..Zlowout  datapath strobes, decoded from the state register
//   fsm_state  current state code, for observation
//
// Handshake: start is a request level sampled at a rising edge only while
// busy is low (IDLE); it is neither acknowledged nor queued otherwise. done
// pulses for exactly one cycle at the end of every sequence that is not
// aborted by clr.
//
// Sequences (cycles counted from the start edge):
//   BR  : EVAL -> ADDR -> SUM -> LOAD -> FIN   (done at cycle 5)
//   JAL : LINK -> JUMP -> FIN                  (done at cycle 3)
//   JR  : JUMP -> FIN                          (done at cycle 2)
//   RSV : FIN                                  (done at cycle 1)
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            con_q,
  output logic            busy,
  output logic            done,
  output logic            taken,
  output logic            illegal,
  output logic            Gra,
  output logic            Grb,
  output logic            Rin,
  output logic            Rout,
  output logic            CONin,
  output logic            PCout,
  output logic            PCin,
  output logic            Yin,
  output logic            Cout,
  output logic            alu_add,
  output logic            Zin,
  output logic            Zlowout,
  output logic [ST_W-1:0] fsm_state
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nx;
  logic [OP_W-1:0] op_r;

  // First state of each sequence, chosen from the live op at the start edge.
  function automatic logic [ST_W-1:0] entry_state(input logic [OP_W-1:0] o);
    if (o == OP_W'(OP_BR))       return ST_EVAL;
    else if (o == OP_W'(OP_JR))  return ST_JUMP;
    else if (o == OP_W'(OP_JAL)) return ST_LINK;
    else                         return ST_FIN;
  endfunction

  // Next-state logic. After the start edge only op_r matters; JAL reaches
  // JUMP through LINK, so JUMP always proceeds straight to FIN.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = entry_state(op);
      ST_EVAL: state_nx = ST_ADDR;
      ST_ADDR: state_nx = ST_SUM;
      ST_SUM:  state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_FIN;
      ST_LINK: state_nx = ST_JUMP;
      ST_JUMP: state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_IDLE;   // start is deliberately not looked at here
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, latched op and branch outcome share one register block so clr
  // clears them together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      op_r  <= '0;
      taken <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) op_r <= op;
      if (state == ST_LOAD) taken <= con_q;
    end
  end

  // Strobe decode. Only one bus driver (Rout, PCout, Cout, Zlowout) and at
  // most one register load (PCin, Rin) is active in any state. PCin in LOAD
  // is the one strobe qualified by con_q: it is the branch decision itself.
  always_comb begin
    Gra     = 1'b0;
    Grb     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    PCout   = 1'b0;
    PCin    = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    alu_add = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    case (state)
      ST_EVAL: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        CONin = 1'b1;
      end
      ST_ADDR: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      ST_SUM: begin
        Cout    = 1'b1;
        alu_add = 1'b1;
        Zin     = 1'b1;
      end
      ST_LOAD: begin
        Zlowout = 1'b1;
        PCin    = con_q;
      end
      ST_LINK: begin
        PCout = 1'b1;
        Grb   = 1'b1;
        Rin   = 1'b1;
      end
      ST_JUMP: begin
        Gra  = 1'b1;
        Rout = 1'b1;
        PCin = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign illegal   = (state == ST_FIN) && (op_r == OP_W'(OP_RSV));
  assign fsm_state = state;

endmodule : branch_sequencer

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL: parameter OP_W, default 2, width of op.
REQ-002 SHALL: clk  input  1  single rising-edge clock.
REQ-003 SHALL: clr  input  1  asynchronous, active-high reset.
REQ-004 SHALL: start  input  1  request to execute the instruction held in op; sampled at a rising edge.
REQ-005 SHALL: op  input  OP_W  instruction class: 00 BR (conditional branch), 01 JR, 10 JAL, 11 reserved.
REQ-006 SHALL: con_q  input  1  condition flip-flop output.
REQ-007 SHALL: busy  output  1  high while a sequence is in progress.
REQ-008 SHALL: done  output  1  one-cycle completion pulse.
REQ-009 SHALL: taken  output  1  registered result of the last BR: 1 if PC was loaded.
REQ-010 SHALL: illegal  output  1  one-cycle pulse for reserved op.
REQ-011 SHALL: Gra, Grb, Rin, Rout, CONin, PCout, PCin, Yin, Cout, alu_add, Zin, Zlowout  output  1 each  datapath strobes.

Function
REQ-012 SHALL: FSM states are IDLE, EVAL, ADDR, SUM, LOAD, LINK, JUMP, FIN; all strobes are Moore outputs decoded from state only.
REQ-013 SHALL: in IDLE, start=1 latches op into op_r and moves the FSM to EVAL (BR), JUMP (JR), LINK (JAL) or FIN (reserved).
REQ-014 SHALL: for BR, the sequence is EVAL (Gra, Rout, CONin), then ADDR (PCout, Yin), then SUM (Cout, alu_add, Zin), then LOAD (Zlowout; PCin only if con_q=1), then FIN.
REQ-015 SHALL: in LOAD, taken is updated to con_q at the exiting edge; taken is unchanged by JR, JAL and reserved ops.
REQ-016 SHALL: for JAL, the sequence is LINK (PCout, Grb, Rin), then JUMP, then FIN.
REQ-017 SHALL: for JR, the sequence is JUMP (Gra, Rout, PCin), then FIN.
REQ-018 SHALL: for a reserved op, the FSM goes directly to FIN, illegal=1 in FIN, and no strobe is asserted.
REQ-019 SHALL: FIN asserts done for exactly one cycle and returns to IDLE unconditionally.
REQ-020 SHALL: busy=1 in every state except IDLE; busy is therefore low in the cycle start is sampled.
REQ-021 SHALL: start while busy is ignored and not queued; start held high in the FIN cycle is not sampled, and a new sequence starts only when start is seen in IDLE.
REQ-022 SHALL: latency, counted from the start edge to the done cycle, is BR 5 cycles, JAL 3, JR 2, reserved 1.
REQ-023 SHALL: no more than one of PCin/Rin and no more than one bus driver (Rout, PCout, Cout, Zlowout) is asserted in any cycle.
REQ-024 SHALL: op changing during a sequence has no effect; op_r governs the sequence.

Reset
REQ-025 SHALL: clr=1 asynchronously forces IDLE, op_r=0, taken=0, and all outputs including strobes, busy, done and illegal to 0, independent of clk.
REQ-026 SHALL: clr asserted mid-sequence aborts it with no done pulse; the first start after clr deasserts is sampled at the next clk edge.

Structure
REQ-027 SHALL: op encodings and the state encoding live in shared package cpu_ctrl_pkg.
REQ-028 SHALL: the design is a single module with no sub-module; the state register and the taken/op_r registers share one always block with async clr.

Verification
REQ-029 SHALL: BR with con_q=1 and start pulsed at edge 0 -> EVAL, ADDR, SUM, LOAD with PCin=1, done at cycle 5, taken=1.
REQ-030 SHALL: BR with con_q=0 -> LOAD with PCin=0, done at cycle 5, taken=0.
REQ-031 SHALL: JAL -> LINK with PCout=Grb=Rin=1, then JUMP with Gra=Rout=PCin=1, then done; JR -> done at cycle 2; taken unchanged from its previous value.
REQ-032 SHALL: op=11 -> illegal=1 and done=1 in the same single cycle, with every strobe 0.
REQ-033 SHALL: clr pulsed during SUM of a BR -> all outputs are 0 immediately, no done pulse, and a following JR completes normally.
REQ-034 SHALL: start held high continuously -> back-to-back sequences with exactly one IDLE cycle between done and the next EVAL; the bench also checks the REQ-023 one-hot rule every cycle.
